// File: rtl/lsp_prev_extract_pkg.sv
// Shared constants, FSM encoding and the ITU saturating basic operators
// used by the LSP residual extractor.
package lsp_prev_extract_pkg;

    localparam int M     = 10;
    localparam int MA_NP = 4;

    localparam logic [11:0] FG_BASE         = 12'd0;
    localparam logic [11:0] FG_SUM_INV_BASE = 12'd128;

    typedef enum logic [3:0] {
        IDLE,
        C0, C1, C2, C3, C4, C5, C6, C7,
        DONE
    } state_t;

    // (a*b)<<1; the only overflowing product is 0x8000*0x8000.
    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
        return p <<< 1;
    endfunction

    function automatic logic [31:0] l_sub(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {a[31], a} - {b[31], b};
        if (d[32] != d[31]) return d[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return d[31:0];
    endfunction

    // Shift left by 3; the three bits shifted past the sign must match it.
    function automatic logic [31:0] l_shl3(input logic [31:0] a);
        if (!a[31] && a[30:28] != 3'b000) return 32'h7FFF_FFFF;
        if (a[31] && a[30:28] != 3'b111)  return 32'h8000_0000;
        return {a[28:0], 3'b000};
    endfunction

endpackage

// File: rtl/lsp_prev_extract_if.sv
// Bus bundle of the extractor: control, base addresses, scratch and constant memory ports.
// Handshake: start is a one-cycle request honoured only while idle; done is a one-cycle
// completion pulse; memory read data is valid the cycle after its address is presented.
interface lsp_prev_extract_if;
    import lsp_prev_extract_pkg::*;

    logic        start;
    logic        mode;
    logic [10:0] lspAddr;
    logic [10:0] lsp_eleAddr;
    logic [10:0] freq_prevAddr;
    logic [31:0] memIn;
    logic [31:0] constMemIn;
    logic [10:0] memReadAddr;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic [11:0] constMemAddr;
    logic        done;
    state_t      dbgState;

    modport master (
        output start, mode, lspAddr, lsp_eleAddr, freq_prevAddr, memIn, constMemIn,
        input  memReadAddr, memWriteAddr, memOut, memWriteEn, constMemAddr, done, dbgState
    );

    modport slave (
        input  start, mode, lspAddr, lsp_eleAddr, freq_prevAddr, memIn, constMemIn,
        output memReadAddr, memWriteAddr, memOut, memWriteEn, constMemAddr, done, dbgState
    );

endinterface

// File: rtl/lsp_prev_extract_mac.sv
// Combinational datapath: one MA-predictor subtract step and the final
// scale-by-fg_sum_inv-and-shift producing the 16-bit residual.
module lsp_prev_extract_mac
    import lsp_prev_extract_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [15:0] freqPrev,
    input  logic [15:0] fg,
    input  logic [15:0] inv,
    output logic [31:0] accNext,
    output logic [15:0] res
);

    logic [31:0] scaled;

    always_comb begin
        accNext = l_sub(acc, l_mult(freqPrev, fg));
        scaled  = l_shl3(l_mult(acc[31:16], inv));
        res     = scaled[31:16];
    end

endmodule

// File: rtl/lsp_prev_extract.sv
// Rebuilds lsp_ele[j] from lsp[j] and the MA history, eight cycles per coefficient,
// writing each result back to scratch memory.
module lsp_prev_extract
    import lsp_prev_extract_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    lsp_prev_extract_if.slave  bus
);

    state_t      state, stateNext;
    logic [3:0]  j;
    logic        modeReg;
    logic [6:0]  lspBase;
    logic [6:0]  eleBase;
    logic [4:0]  fpBase;
    logic [31:0] acc;
    logic [15:0] inv;
    logic [15:0] res;
    logic [31:0] accNext;
    logic [15:0] resNext;
    logic [1:0]  issueK;
    logic        unusedBits;

    assign unusedBits = ^{bus.memIn[31:16], bus.constMemIn[31:16], bus.lspAddr[3:0],
                          bus.lsp_eleAddr[3:0], bus.freq_prevAddr[5:0]};

    lsp_prev_extract_mac mac (
        .acc      (acc),
        .freqPrev (bus.memIn[15:0]),
        .fg       (bus.constMemIn[15:0]),
        .inv      (inv),
        .accNext  (accNext),
        .res      (resNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            j       <= 4'd0;
            modeReg <= 1'b0;
            lspBase <= 7'd0;
            eleBase <= 7'd0;
            fpBase  <= 5'd0;
            acc     <= 32'd0;
            inv     <= 16'd0;
            res     <= 16'd0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (bus.start) begin
                    modeReg <= bus.mode;
                    lspBase <= bus.lspAddr[10:4];
                    eleBase <= bus.lsp_eleAddr[10:4];
                    fpBase  <= bus.freq_prevAddr[10:6];
                end
                C1: begin
                    acc <= {bus.memIn[15:0], 16'h0000};
                    inv <= bus.constMemIn[15:0];
                end
                C2, C3, C4, C5: acc <= accNext;
                C6:   res <= resNext;
                C7:   if (j != 4'(M - 1)) j <= j + 4'd1;
                DONE: j <= 4'd0;
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext        = state;
        issueK           = 2'd0;
        bus.memReadAddr  = 11'd0;
        bus.memWriteAddr = 11'd0;
        bus.memOut       = 32'd0;
        bus.memWriteEn   = 1'b0;
        bus.constMemAddr = 12'd0;
        bus.done         = 1'b0;
        bus.dbgState     = state;

        case (state)
            IDLE: if (bus.start) stateNext = C0;
            C0: begin
                bus.memReadAddr  = {lspBase, j};
                bus.constMemAddr = FG_SUM_INV_BASE + 12'({modeReg, j});
                stateNext        = C1;
            end
            // Rows 0..3 of freq_prev/fg are issued in C1..C4 and consumed one cycle later.
            C1, C2, C3, C4: begin
                case (state)
                    C2:      issueK = 2'd1;
                    C3:      issueK = 2'd2;
                    C4:      issueK = 2'd3;
                    default: issueK = 2'd0;
                endcase
                bus.memReadAddr  = {fpBase, issueK, j};
                bus.constMemAddr = FG_BASE + 12'({modeReg, issueK, j});
                stateNext        = state.next();
            end
            C5: stateNext = C6;
            C6: stateNext = C7;
            C7: begin
                bus.memWriteAddr = {eleBase, j};
                bus.memOut       = {{16{res[15]}}, res};
                bus.memWriteEn   = 1'b1;
                stateNext        = (j == 4'(M - 1)) ? DONE : C0;
            end
            DONE: begin
                bus.done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsp_prev_extract.sv
// Randomized scoreboard bench for lsp_prev_extract with memory models and an
// arithmetic reference model of the residual extraction.
module tb_lsp_prev_extract;
  import lsp_prev_extract_pkg::*;

  localparam int W = 43;  // {write address, 32-bit write data}

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  lsp_prev_extract_if bus();

  lsp_prev_extract dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory models ----------------
  logic [15:0] smem [2048];
  logic [15:0] cmem [4096];

  always @(posedge clk) begin
    bus.memIn      <= {~smem[bus.memReadAddr], smem[bus.memReadAddr]};
    bus.constMemIn <= {16'hA5C3, cmem[bus.constMemAddr]};
    if (bus.memWriteEn) smem[bus.memWriteAddr] <= bus.memOut[15:0];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           done_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           run_writes = 0;
  bit           done_seen = 0;
  logic [W-1:0] exp_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %h expected nothing (t=%0t)", name, act, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.memWriteEn) begin
        run_writes++;
        if (exp_q.size() == 0) flag("unexpected_write", {21'd0, bus.memWriteAddr, bus.memOut});
        else begin
          exp_word = exp_q.pop_front();
          check("write", {21'd0, bus.memWriteAddr, bus.memOut}, {21'd0, exp_word});
        end
      end
      if (bus.done) begin
        done_seen = 1;
        if (done_q.size() == 0) flag("unexpected_done", 64'(cyc));
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        check("write_count", 64'(run_writes), 64'd10);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        run_writes = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic longint sat32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint lmult(input longint a, input longint b);
    if (a == -32768 && b == -32768) return 64'sd2147483647;
    return a * b * 2;
  endfunction

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [15:0] model_ele(input logic md, input logic [10:0] lsp_a,
                                            input logic [10:0] fp_a, input int j);
    longint acc;
    longint p;
    int     lsp_row;
    int     fp_row;
    lsp_row = int'(lsp_a[10:4]) * 16;
    fp_row  = int'(fp_a[10:6]) * 64;
    acc = s16(smem[lsp_row + j]) * 65536;
    for (int k = 0; k < MA_NP; k++)
      acc = sat32(acc - lmult(s16(smem[fp_row + k * 16 + j]),
                              s16(cmem[int'(FG_BASE) + int'(md) * 64 + k * 16 + j])));
    p = sat32(lmult(acc >>> 16, s16(cmem[int'(FG_SUM_INV_BASE) + int'(md) * 16 + j])) * 8);
    return 16'(p >>> 16);
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] rand_val(input int kind);
    if (kind == 0) return 16'($urandom);
    return 16'($urandom_range(0, 16'h1FFF)) - 16'h1000;
  endfunction

  task automatic fill_rom(input int kind);
    for (int a = 0; a < 160; a++) cmem[a] = rand_val(kind);
  endtask

  task automatic fill_frame(input logic [10:0] lsp_a, input logic [10:0] fp_a, input int kind);
    for (int j = 0; j < M; j++) begin
      smem[int'(lsp_a[10:4]) * 16 + j] = rand_val(kind);
      for (int k = 0; k < MA_NP; k++) smem[int'(fp_a[10:6]) * 64 + k * 16 + j] = rand_val(kind);
    end
  endtask

  task automatic push_expected(input logic md, input logic [10:0] lsp_a,
                               input logic [10:0] ele_a, input logic [10:0] fp_a);
    logic [15:0] r;
    for (int j = 0; j < M; j++) begin
      r = model_ele(md, lsp_a, fp_a, j);
      exp_q.push_back({ele_a[10:4], 4'(j), {16{r[15]}}, r});
    end
  endtask

  task automatic pulse_start(input logic md, input logic [10:0] lsp_a,
                             input logic [10:0] ele_a, input logic [10:0] fp_a, output int n);
    @(posedge clk); #1;
    bus.mode = md;
    bus.lspAddr = lsp_a;
    bus.lsp_eleAddr = ele_a;
    bus.freq_prevAddr = fp_a;
    bus.start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // Scramble the inputs so only the latched copies can be right.
    bus.mode = 1'($urandom);
    bus.lspAddr = 11'($urandom);
    bus.lsp_eleAddr = 11'($urandom);
    bus.freq_prevAddr = 11'($urandom);
  endtask

  task automatic run_frame(input logic md, input logic [10:0] lsp_a, input logic [10:0] ele_a,
                           input logic [10:0] fp_a, input bit repulse);
    int n;
    push_expected(md, lsp_a, ele_a, fp_a);
    done_seen = 0;
    pulse_start(md, lsp_a, ele_a, fp_a, n);
    done_q.push_back(n + 81);
    if (repulse) begin
      repeat (19) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    for (int t = 0; t < 200 && !done_seen; t++) @(posedge clk);
    if (!done_seen) begin
      flag("done_timeout", 64'(cyc));
      exp_q.delete();
      done_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic run_abort(input int offset);
    int n;
    logic [10:0] lsp_a = 11'h120;
    logic [10:0] ele_a = 11'h230;
    logic [10:0] fp_a = 11'h440;
    fill_frame(lsp_a, fp_a, 1);
    push_expected(1'b0, lsp_a, ele_a, fp_a);
    pulse_start(1'b0, lsp_a, ele_a, fp_a, n);
    done_q.push_back(n + 81);
    repeat (offset - 1) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    run_writes = 0;
    #1;
    check("abort_memWriteEn", 64'(bus.memWriteEn), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // No stray writes or done pulse may follow an aborted run.
    repeat (100) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] lsp_a, ele_a, fp_a;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.lspAddr = 11'd0;
    bus.lsp_eleAddr = 11'd0;
    bus.freq_prevAddr = 11'd0;
    for (int a = 0; a < 2048; a++) smem[a] = 16'($urandom);
    for (int a = 0; a < 4096; a++) cmem[a] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_memReadAddr", 64'(bus.memReadAddr), 64'd0);
    check("rst_memWriteAddr", 64'(bus.memWriteAddr), 64'd0);
    check("rst_memOut", 64'(bus.memOut), 64'd0);
    check("rst_memWriteEn", 64'(bus.memWriteEn), 64'd0);
    check("rst_constMemAddr", 64'(bus.constMemAddr), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;

    // Zero history: residual is lsp scaled by fg_sum_inv.
    lsp_a = 11'h105; ele_a = 11'h20A; fp_a = 11'h400;
    for (int j = 0; j < M; j++) begin
      smem[16'h100 + j] = 16'h1000;
      for (int k = 0; k < MA_NP; k++) smem[16'h400 + k * 16 + j] = 16'h0000;
      cmem[128 + j] = 16'h2000;
      cmem[144 + j] = 16'h2000;
    end
    run_frame(1'b1, lsp_a, ele_a, fp_a, 0);
    for (int j = 0; j < M; j++) check($sformatf("zero_hist_ele%0d", j), 64'(smem[16'h200 + j]), 64'h2000);

    // Saturating accumulator and saturating final shift.
    for (int j = 0; j < M; j++) begin
      smem[16'h100 + j] = 16'h7FFF;
      for (int k = 0; k < MA_NP; k++) begin
        smem[16'h400 + k * 16 + j] = 16'h8000;
        cmem[k * 16 + j] = 16'h7FFF;
      end
      cmem[128 + j] = 16'h7FFF;
    end
    run_frame(1'b0, lsp_a, ele_a, fp_a, 0);
    for (int j = 0; j < M; j++) check($sformatf("sat_ele%0d", j), 64'(smem[16'h200 + j]), 64'h7FFF);

    // Start re-pulsed mid-run must be ignored.
    fill_rom(0);
    fill_frame(lsp_a, fp_a, 0);
    run_frame(1'b1, lsp_a, ele_a, fp_a, 1);

    // Reset in the middle of a run, then a clean run.
    run_abort(30);
    run_frame(1'b0, lsp_a, ele_a, fp_a, 0);
    run_abort(32);
    run_frame(1'b1, lsp_a, ele_a, fp_a, 0);

    // Results written over the lsp[] they come from.
    fill_frame(11'h130, fp_a, 1);
    run_frame(1'b0, 11'h130, 11'h13F, fp_a, 0);

    // Random frames in both modes, full-range and speech-like value ranges.
    for (int f = 0; f < 24; f++) begin
      if (f % 6 == 0) fill_rom(f % 12 == 0 ? 1 : 0);
      lsp_a = {3'b001, 4'($urandom), 4'($urandom)};
      ele_a = {3'b010, 4'($urandom), 4'($urandom)};
      fp_a  = {3'b100, 2'($urandom), 6'($urandom)};
      fill_frame(lsp_a, fp_a, int'($urandom_range(0, 1)));
      run_frame(1'(f), lsp_a, ele_a, fp_a, 0);
    end

    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_q_empty", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
